// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default latencies for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    StRun,
    StMcWait
  } state_e;

  localparam int unsigned FpLatDef  = 3;
  localparam int unsigned FmaLatDef = 4;
  localparam int unsigned FftLatDef = 8;

  // Counter preload: the start cycle and the mc_done cycle are not counted down.
  function automatic logic [3:0] lat_cnt_init(input logic        fft,
                                              input logic        fma,
                                              input int unsigned fp_lat,
                                              input int unsigned fma_lat,
                                              input int unsigned fft_lat);
    logic [3:0] l;
    if (fft) begin
      l = 4'(fft_lat);
    end else if (fma) begin
      l = 4'(fma_lat);
    end else begin
      l = 4'(fp_lat);
    end
    return l - 4'd2;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Load-use detector: EX load destination against the used ID source indices.
module hazard_cmp (
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic [4:0] rs3_id,
  input  logic       use_rs1_id,
  input  logic       use_rs2_id,
  input  logic       use_rs3_id,
  input  logic       fp_src_id,
  input  logic [4:0] rd_ex,
  input  logic       mem_read_ex,
  input  logic       fp_reg_write_ex,
  output logic       lu
);

  logic dest_ok;
  logic file_ok;
  logic src_hit;

  // x0 is hardwired in the integer file; f0 is a real register.
  assign dest_ok = (rd_ex != 5'd0) | fp_reg_write_ex;
  assign file_ok = (fp_reg_write_ex == fp_src_id);
  assign src_hit = (use_rs1_id & (rs1_id == rd_ex)) |
                   (use_rs2_id & (rs2_id == rd_ex)) |
                   (use_rs3_id & (rs3_id == rd_ex));

  assign lu = mem_read_ex & dest_ok & file_ok & src_hit;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: branch flush, load-use bubble and multi-cycle EX hold.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FP_LAT  = FpLatDef,
  parameter int unsigned FMA_LAT = FmaLatDef,
  parameter int unsigned FFT_LAT = FftLatDef
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic [4:0]  rs3_id,
  input  logic        use_rs1_id,
  input  logic        use_rs2_id,
  input  logic        use_rs3_id,
  input  logic        fp_src_id,
  input  logic [4:0]  rd_ex,
  input  logic        mem_read_ex,
  input  logic        fp_reg_write_ex,
  input  logic        fp_op_ex,
  input  logic        fma_op_ex,
  input  logic        fft_op_ex,
  input  logic        branch_taken_ex,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        id_ex_stall,
  output logic        mc_busy,
  output logic        mc_done,
  output logic [15:0] stall_cycles
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        just_done_q;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        lu;
  logic        ms;

  hazard_cmp u_hazard_cmp (
    .rs1_id          (rs1_id),
    .rs2_id          (rs2_id),
    .rs3_id          (rs3_id),
    .use_rs1_id      (use_rs1_id),
    .use_rs2_id      (use_rs2_id),
    .use_rs3_id      (use_rs3_id),
    .fp_src_id       (fp_src_id),
    .rd_ex           (rd_ex),
    .mem_read_ex     (mem_read_ex),
    .fp_reg_write_ex (fp_reg_write_ex),
    .lu              (lu)
  );

  // The op that just completed may still be visible in EX for one cycle.
  assign ms = (fp_op_ex | fft_op_ex) & ~branch_taken_ex & ~just_done_q;

  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    id_ex_stall = 1'b0;
    mc_busy     = 1'b0;
    mc_done     = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    if (rst_n) begin
      unique case (state_q)
        StRun: begin
          if (branch_taken_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (ms) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
            mc_busy     = 1'b1;
            cnt_d       = lat_cnt_init(fft_op_ex, fma_op_ex, FP_LAT, FMA_LAT, FFT_LAT);
            state_d     = StMcWait;
          end else if (lu) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        StMcWait: begin
          mc_busy = 1'b1;
          if (cnt_q != 4'd0) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
            cnt_d       = cnt_q - 4'd1;
          end else begin
            mc_done = 1'b1;
            state_d = StRun;
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      cnt_q       <= 4'd0;
      just_done_q <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      just_done_q <= mc_done;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter FP_LAT, default 3: EX occupancy in cycles of a non-FMA FP op; legal range 2..15.
REQ-002 Parameter FMA_LAT, default 4: EX occupancy of an FMA op; legal range 2..15.
REQ-003 Parameter FFT_LAT, default 8: EX occupancy of an FFT op; legal range 2..15.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 rs1_id, rs2_id, rs3_id  in  5 each  source register indices of the instruction in ID.
REQ-007 use_rs1_id, use_rs2_id, use_rs3_id  in  1 each  source is actually read.
REQ-008 fp_src_id  in  1  ID sources index the FP register file (0 = integer file).
REQ-009 rd_ex  in  5  destination index of the instruction in EX.
REQ-010 mem_read_ex, fp_reg_write_ex  in  1 each  EX instruction is a load; its destination is the FP file.
REQ-011 fp_op_ex, fma_op_ex, fft_op_ex  in  1 each  EX instruction is an FP / FMA / FFT op.
REQ-012 branch_taken_ex  in  1  EX resolved a taken branch or jump (redirect).
REQ-013 pc_stall, if_id_stall  out  1 each  hold PC and IF/ID.
REQ-014 if_id_flush, id_ex_flush  out  1 each  bubble IF/ID and ID/EX.
REQ-015 id_ex_stall  out  1  hold ID/EX (EX occupant stays).
REQ-016 mc_busy, mc_done  out  1 each  multi-cycle op in progress; its final EX cycle.
REQ-017 stall_cycles  out  16  saturating count of cycles with pc_stall=1.

Function
REQ-018 FSM states: RUN, MC_WAIT. A 4-bit down-counter cnt is active only in MC_WAIT.
REQ-019 Load-use hazard (lu): mem_read_ex=1, rd_ex!=0 (an FP destination f0 counts), fp_reg_write_ex==fp_src_id, and the index of any used source (rs1/rs2/rs3) equals rd_ex.
REQ-020 An integer-file x0 destination never raises lu.
REQ-021 Multi-cycle start (ms): state RUN, (fp_op_ex|fft_op_ex)=1, branch_taken_ex=0.
REQ-022 Latency select L: FFT_LAT if fft_op_ex, else FMA_LAT if fma_op_ex, else FP_LAT.
REQ-023 Priority 1, branch_taken_ex=1: if_id_flush=id_ex_flush=1 for that cycle; all stalls 0; lu ignored; no MC start.
REQ-024 Priority 2, ms in RUN: pc_stall=if_id_stall=id_ex_stall=1 and mc_busy=1; cnt<=L-2; next state MC_WAIT.
REQ-025 In MC_WAIT with cnt!=0: all three stalls=1, mc_busy=1, cnt decrements.
REQ-026 In MC_WAIT with cnt==0: stalls=0, mc_done=1, mc_busy=1; next state RUN.
REQ-027 The occupant does not re-trigger ms in the cycle after MC_WAIT.
REQ-028 Net effect: an MC op occupies EX exactly L cycles, with L-1 stall cycles.
REQ-029 Priority 3, lu in RUN without ms: pc_stall=if_id_stall=1 and id_ex_flush=1 for one cycle; id_ex_stall=0.
REQ-030 lu is not evaluated in MC_WAIT; a lu against the following load is evaluated normally once in RUN.
REQ-031 All flush/stall/mc outputs are combinational from state, cnt and inputs; no output latency.
REQ-032 stall_cycles increments on each cycle with pc_stall=1 and saturates at 16'hFFFF.
REQ-033 X on inputs while rst_n=0 has no effect.

Reset
REQ-034 rst_n=0 forces, immediately: state=RUN, cnt=0, stall_cycles=0.
REQ-035 While rst_n=0, all combinational outputs are 0.
REQ-036 Reset asserted in MC_WAIT aborts the op; the first cycle after release is RUN.

Structure
REQ-037 Package pipe_ctrl_pkg holds the state enum and the default latency constants.
REQ-038 Sub-module hazard_cmp holds the index-compare logic for REQ-019 and REQ-020.
REQ-039 Target RTL size: 120-400 lines.

Verification
REQ-040 Load x5 in EX, ID reads x5 via rs2 -> one cycle of pc_stall/if_id_stall/id_ex_flush; stall_cycles=1.
REQ-041 Load x0 in EX, ID reads x0 -> no stall or flush.
REQ-042 fft_op_ex with FFT_LAT=8 -> 7 stall cycles, then mc_done=1 for one cycle, then RUN with no re-trigger.
REQ-043 FMA (L=4) and FP (L=2) each -> 3 and 1 stall cycles; mc_done follows each.
REQ-044 branch_taken_ex=1 together with a lu condition -> if_id_flush=id_ex_flush=1, pc_stall=0.
REQ-045 rst_n low at cnt=3 in MC_WAIT -> outputs 0 immediately; after release, state RUN and stall_cycles=0.
